// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory stalls, instruction-fetch
// misses, load-use hazards, EX-stage redirects and halt, and drives the
// enable/flush pair of every pipeline latch plus the PC write enable.
// A latch loads when en=1, loads a bubble when en=1 & flush=1, and holds
// when en=0. All enable/flush decisions are combinational (same-cycle).
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_mem,
    input  logic             dWEN_mem,
    input  logic             halt_mem,
    input  logic             dREN_ex,
    input  logic             RegWr_ex,
    input  logic [4:0]       wsel_ex,
    input  logic             jumpFlush_ex,
    input  logic             branch_taken_ex,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             uses_rt_id,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    // Control pair for one pipeline latch.
    typedef struct packed {
        logic en;
        logic flush;
    } latch_ctrl_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t      state, state_nxt;
    latch_ctrl_t ifid_c, idex_c, exmem_c, memwb_c;
    logic        pc_we;
    logic        halted_o;
    logic        mem_stall, redirect, load_use;
    logic        rs_match, rt_match;
    logic        stall_inc, flush_inc;

    // Hazard detection terms from the MEM, EX and ID stages.
    always_comb begin
        mem_stall = (dREN_mem | dWEN_mem) & ~dhit;
        redirect  = branch_taken_ex | jumpFlush_ex;
        rs_match  = (wsel_ex == rs_id);
        rt_match  = uses_rt_id & (wsel_ex == rt_id);
        // r0 is hardwired zero, so writing it never creates a dependency.
        load_use  = dREN_ex & RegWr_ex & (wsel_ex != 5'd0) & (rs_match | rt_match);
    end

    // Next state and latch controls; the first matching condition wins.
    always_comb begin
        state_nxt = state;
        pc_we     = 1'b1;
        ifid_c    = '{en: 1'b1, flush: 1'b0};
        idex_c    = '{en: 1'b1, flush: 1'b0};
        exmem_c   = '{en: 1'b1, flush: 1'b0};
        memwb_c   = '{en: 1'b1, flush: 1'b0};
        halted_o  = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall || (!ihit && redirect)) begin
                    // Freeze everything upstream of MEM/WB; WB gets a bubble.
                    // A pending redirect is simply re-seen next cycle.
                    pc_we   = 1'b0;
                    ifid_c  = '{en: 1'b0, flush: 1'b0};
                    idex_c  = '{en: 1'b0, flush: 1'b0};
                    exmem_c = '{en: 1'b0, flush: 1'b0};
                    memwb_c = '{en: 1'b1, flush: 1'b1};
                end else if (halt_mem) begin
                    // Let the halt retire, bubble behind it, then stop.
                    pc_we     = 1'b0;
                    ifid_c    = '{en: 1'b0, flush: 1'b0};
                    idex_c    = '{en: 1'b0, flush: 1'b0};
                    exmem_c   = '{en: 1'b1, flush: 1'b1};
                    state_nxt = HALTED;
                end else if (!ihit) begin
                    // Fetch not ready: hold IF/ID, inject a bubble into EX.
                    pc_we  = 1'b0;
                    ifid_c = '{en: 1'b0, flush: 1'b0};
                    idex_c = '{en: 1'b1, flush: 1'b1};
                end else if (redirect) begin
                    // Squash the two wrong-path instructions in IF/ID and ID/EX.
                    ifid_c    = '{en: 1'b1, flush: 1'b1};
                    idex_c    = '{en: 1'b1, flush: 1'b1};
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    // Hold the dependent instruction in ID for one cycle.
                    pc_we  = 1'b0;
                    ifid_c = '{en: 1'b0, flush: 1'b0};
                    idex_c = '{en: 1'b1, flush: 1'b1};
                end
                stall_inc = ~pc_we;
            end
            HALTED: begin
                pc_we    = 1'b0;
                ifid_c   = '{en: 1'b0, flush: 1'b0};
                idex_c   = '{en: 1'b0, flush: 1'b0};
                exmem_c  = '{en: 1'b0, flush: 1'b0};
                memwb_c  = '{en: 1'b0, flush: 1'b0};
                halted_o = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign pc_en       = pc_we;
    assign ifid_en     = ifid_c.en;
    assign ifid_flush  = ifid_c.flush;
    assign idex_en     = idex_c.en;
    assign idex_flush  = idex_c.flush;
    assign exmem_en    = exmem_c.en;
    assign exmem_flush = exmem_c.flush;
    assign memwb_en    = memwb_c.en;
    assign memwb_flush = memwb_c.flush;
    assign halted      = halted_o;

    // State register; halt is sticky until reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= RUN;
        else     state <= state_nxt;
    end

    // Saturating performance counters; neither advances while halted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with constant
// expectations, then randomized traffic checked against a reference model.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    // Expected vector {pc, ifid_en, ifid_fl, idex_en, idex_fl,
    //                  exmem_en, exmem_fl, memwb_en, memwb_fl, halted}
    localparam logic [9:0] V_FREEZE = 10'b0000000110;
    localparam logic [9:0] V_HALT   = 10'b0000011100;
    localparam logic [9:0] V_BUBBLE = 10'b0001110100;
    localparam logic [9:0] V_REDIR  = 10'b1111110100;
    localparam logic [9:0] V_NORMAL = 10'b1101010100;
    localparam logic [9:0] V_HALTED = 10'b0000000001;

    typedef struct {
        logic       ihit, dhit, dREN_mem, dWEN_mem, halt_mem;
        logic       dREN_ex, RegWr_ex, jumpFlush_ex, branch_taken_ex, uses_rt_id;
        logic [4:0] wsel_ex, rs_id, rt_id;
    } in_t;

    logic CLK = 1'b0, RST = 1'b1;
    logic ihit, dhit, dREN_mem, dWEN_mem, halt_mem, dREN_ex, RegWr_ex;
    logic jumpFlush_ex, branch_taken_ex, uses_rt_id;
    logic [4:0] wsel_ex, rs_id, rt_id;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, exmem_flush, memwb_en, memwb_flush, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .halt_mem(halt_mem),
        .dREN_ex(dREN_ex), .RegWr_ex(RegWr_ex), .wsel_ex(wsel_ex),
        .jumpFlush_ex(jumpFlush_ex), .branch_taken_ex(branch_taken_ex),
        .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [9:0] dut_vec();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                exmem_en, exmem_flush, memwb_en, memwb_flush, halted};
    endfunction

    function automatic in_t idle();
        in_t s;
        s = '{ihit: 1'b1, dhit: 1'b0, dREN_mem: 1'b0, dWEN_mem: 1'b0, halt_mem: 1'b0,
              dREN_ex: 1'b0, RegWr_ex: 1'b0, jumpFlush_ex: 1'b0, branch_taken_ex: 1'b0,
              uses_rt_id: 1'b0, wsel_ex: 5'd0, rs_id: 5'd0, rt_id: 5'd0};
        return s;
    endfunction

    // Reference: which stage-control pattern the rules select for one cycle.
    function automatic logic [9:0] ref_vec(in_t s, bit hlt);
        bit mem_busy, redir, hazard;
        mem_busy = (s.dREN_mem || s.dWEN_mem) && !s.dhit;
        redir    = s.branch_taken_ex || s.jumpFlush_ex;
        hazard   = s.dREN_ex && s.RegWr_ex && (s.wsel_ex != 0) &&
                   ((s.wsel_ex == s.rs_id) || (s.uses_rt_id && s.wsel_ex == s.rt_id));
        if (hlt)                          return V_HALTED;
        if (mem_busy || (!s.ihit && redir)) return V_FREEZE;
        if (s.halt_mem)                   return V_HALT;
        if (!s.ihit)                      return V_BUBBLE;
        if (redir)                        return V_REDIR;
        if (hazard)                       return V_BUBBLE;
        return V_NORMAL;
    endfunction

    // Apply inputs on the falling edge and let combinational outputs settle.
    task automatic drive(in_t s);
        @(negedge CLK);
        ihit = s.ihit; dhit = s.dhit; dREN_mem = s.dREN_mem; dWEN_mem = s.dWEN_mem;
        halt_mem = s.halt_mem; dREN_ex = s.dREN_ex; RegWr_ex = s.RegWr_ex;
        jumpFlush_ex = s.jumpFlush_ex; branch_taken_ex = s.branch_taken_ex;
        uses_rt_id = s.uses_rt_id; wsel_ex = s.wsel_ex; rs_id = s.rs_id; rt_id = s.rt_id;
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(idle());
        #2 RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(idle());
        checks++;
        if (dut_vec() !== V_NORMAL) begin errors++;
            $display("FAIL reset_ctrl got %b want %b", dut_vec(), V_NORMAL); end
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin errors++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        #2 RST = 1'b0;
        drive(idle());
        checks++;
        if (dut_vec() !== V_NORMAL || stall_cnt !== 4'd0) begin errors++;
            $display("FAIL post_reset got %b cnt %0d want %b cnt 0", dut_vec(), stall_cnt, V_NORMAL); end
    endtask

    task automatic test_load_use();
        in_t s;
        do_reset();
        s = idle(); s.dREN_ex = 1; s.RegWr_ex = 1; s.wsel_ex = 5'd8; s.rs_id = 5'd8;
        drive(s);
        checks++;
        if (dut_vec() !== V_BUBBLE || stall_cnt !== 4'd0) begin errors++;
            $display("FAIL lu_rs got %b cnt %0d want %b cnt 0", dut_vec(), stall_cnt, V_BUBBLE); end
        s.wsel_ex = 5'd0; s.rs_id = 5'd0;
        drive(s);
        checks++;
        if (dut_vec() !== V_NORMAL || stall_cnt !== 4'd1) begin errors++;
            $display("FAIL lu_r0 got %b cnt %0d want %b cnt 1", dut_vec(), stall_cnt, V_NORMAL); end
        s.wsel_ex = 5'd5; s.rs_id = 5'd3; s.rt_id = 5'd5; s.uses_rt_id = 1;
        drive(s);
        checks++;
        if (dut_vec() !== V_BUBBLE) begin errors++;
            $display("FAIL lu_rt got %b want %b", dut_vec(), V_BUBBLE); end
        s.uses_rt_id = 0;
        drive(s);
        checks++;
        if (dut_vec() !== V_NORMAL || stall_cnt !== 4'd2) begin errors++;
            $display("FAIL lu_rt_unused got %b cnt %0d want %b cnt 2", dut_vec(), stall_cnt, V_NORMAL); end
    endtask

    task automatic test_branch_imiss();
        in_t s;
        do_reset();
        s = idle(); s.branch_taken_ex = 1; s.ihit = 0;
        for (int i = 0; i < 2; i++) begin
            drive(s);
            checks++;
            if (dut_vec() !== V_FREEZE) begin errors++;
                $display("FAIL br_freeze%0d got %b want %b", i, dut_vec(), V_FREEZE); end
        end
        s.ihit = 1;
        drive(s);
        checks++;
        if (dut_vec() !== V_REDIR || stall_cnt !== 4'd2) begin errors++;
            $display("FAIL br_redirect got %b cnt %0d want %b cnt 2", dut_vec(), stall_cnt, V_REDIR); end
        s = idle(); s.jumpFlush_ex = 1; s.dREN_ex = 1; s.RegWr_ex = 1; s.wsel_ex = 5'd4; s.rs_id = 5'd4;
        drive(s);
        checks++;
        if (dut_vec() !== V_REDIR || flush_cnt !== 4'd1) begin errors++;
            $display("FAIL jump_over_lu got %b fcnt %0d want %b fcnt 1", dut_vec(), flush_cnt, V_REDIR); end
        drive(idle());
        checks++;
        if (flush_cnt !== 4'd2 || stall_cnt !== 4'd2) begin errors++;
            $display("FAIL br_counts got %0d/%0d want 2/2", stall_cnt, flush_cnt); end
    endtask

    task automatic test_mem_stall();
        in_t s;
        do_reset();
        s = idle(); s.dWEN_mem = 1; s.dhit = 0;
        s.dREN_ex = 1; s.RegWr_ex = 1; s.wsel_ex = 5'd9; s.rs_id = 5'd9;
        for (int i = 0; i < 3; i++) begin
            drive(s);
            checks++;
            if (dut_vec() !== V_FREEZE) begin errors++;
                $display("FAIL mem_freeze%0d got %b want %b", i, dut_vec(), V_FREEZE); end
        end
        s.dhit = 1;
        drive(s);
        checks++;
        if (dut_vec() !== V_BUBBLE) begin errors++;
            $display("FAIL mem_then_lu got %b want %b", dut_vec(), V_BUBBLE); end
        drive(idle());
        checks++;
        if (stall_cnt !== 4'd4) begin errors++;
            $display("FAIL mem_stall_cnt got %0d want 4", stall_cnt); end
    endtask

    task automatic test_halt();
        in_t s;
        do_reset();
        s = idle(); s.halt_mem = 1;
        drive(s);
        checks++;
        if (dut_vec() !== V_HALT) begin errors++;
            $display("FAIL halt_cycle got %b want %b", dut_vec(), V_HALT); end
        s = idle(); s.ihit = 0; s.branch_taken_ex = 1;
        for (int i = 0; i < 3; i++) begin
            drive(s);
            checks++;
            if (dut_vec() !== V_HALTED || stall_cnt !== 4'd1 || flush_cnt !== 4'd0) begin errors++;
                $display("FAIL halted%0d got %b cnt %0d/%0d want %b cnt 1/0",
                         i, dut_vec(), stall_cnt, flush_cnt, V_HALTED); end
        end
        RST = 1'b1;
        drive(idle());
        checks++;
        if (dut_vec() !== V_NORMAL || stall_cnt !== 4'd0) begin errors++;
            $display("FAIL halt_reset got %b cnt %0d want %b cnt 0", dut_vec(), stall_cnt, V_NORMAL); end
        #2 RST = 1'b0;
        drive(idle());
        checks++;
        if (dut_vec() !== V_NORMAL) begin errors++;
            $display("FAIL halt_rerun got %b want %b", dut_vec(), V_NORMAL); end
    endtask

    task automatic test_saturation();
        in_t s;
        do_reset();
        s = idle(); s.ihit = 0;
        for (int i = 0; i < 20; i++) drive(s);
        drive(idle());
        checks++;
        if (stall_cnt !== 4'd15) begin errors++;
            $display("FAIL stall_sat got %0d want 15", stall_cnt); end
        s = idle(); s.branch_taken_ex = 1;
        for (int i = 0; i < 20; i++) drive(s);
        drive(idle());
        checks++;
        if (flush_cnt !== 4'd15 || stall_cnt !== 4'd15) begin errors++;
            $display("FAIL flush_sat got %0d/%0d want 15/15", stall_cnt, flush_cnt); end
        s = idle(); s.ihit = 0;
        drive(s);
        RST = 1'b1;
        #1;
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || dut_vec() !== V_BUBBLE) begin errors++;
            $display("FAIL midstall_reset got %b cnt %0d/%0d want %b cnt 0/0",
                     dut_vec(), stall_cnt, flush_cnt, V_BUBBLE); end
        #1 RST = 1'b0;
    endtask

    task automatic test_random();
        in_t s;
        logic [9:0] v;
        bit m_hlt = 0;
        int m_stall = 0, m_flush = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (m_hlt && $urandom_range(0, 3) == 0) begin
                RST = 1'b1;
                drive(idle());
                m_hlt = 0; m_stall = 0; m_flush = 0;
                checks++;
                if (dut_vec() !== V_NORMAL || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin errors++;
                    $display("FAIL rnd_reset%0d got %b cnt %0d/%0d", i, dut_vec(), stall_cnt, flush_cnt); end
                #2 RST = 1'b0;
                continue;
            end
            s.ihit            = ($urandom_range(0, 3) != 0);
            s.dhit            = $urandom_range(0, 1);
            s.dREN_mem        = ($urandom_range(0, 3) == 0);
            s.dWEN_mem        = ($urandom_range(0, 5) == 0);
            s.halt_mem        = ($urandom_range(0, 39) == 0);
            s.dREN_ex         = $urandom_range(0, 1);
            s.RegWr_ex        = ($urandom_range(0, 3) != 0);
            s.jumpFlush_ex    = ($urandom_range(0, 7) == 0);
            s.branch_taken_ex = ($urandom_range(0, 5) == 0);
            s.uses_rt_id      = $urandom_range(0, 1);
            s.wsel_ex         = 5'($urandom_range(0, 3));
            s.rs_id           = 5'($urandom_range(0, 3));
            s.rt_id           = 5'($urandom_range(0, 3));
            drive(s);
            v = ref_vec(s, m_hlt);
            checks++;
            if (dut_vec() !== v) begin errors++;
                $display("FAIL rnd_ctrl%0d got %b want %b", i, dut_vec(), v); end
            checks++;
            if (stall_cnt !== 4'(m_stall) || flush_cnt !== 4'(m_flush)) begin errors++;
                $display("FAIL rnd_cnt%0d got %0d/%0d want %0d/%0d",
                         i, stall_cnt, flush_cnt, m_stall, m_flush); end
            if (!m_hlt) begin
                if (!v[9] && m_stall < CMAX) m_stall++;
                if (v == V_REDIR && m_flush < CMAX) m_flush++;
                if (v == V_HALT) m_hlt = 1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_imiss();
        test_mem_stall();
        test_halt();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Drives the `enable`/`flush` pair of every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Consumes the control outputs the ID/EX latch presents to EX, plus ID register selects and memory-stage status.
- Arbitrates cache stalls, load-use hazards, taken branches/jumps and program halt.
- Keeps a sticky halt state and saturating stall/flush performance counters.

Parameters:
CNT_W, 32, width of stall_cnt and flush_cnt performance counters

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-high
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dREN_mem  in  1  load in MEM stage
dWEN_mem  in  1  store in MEM stage
halt_mem  in  1  halt instruction in MEM stage
dREN_ex  in  1  load in EX (ID/EX dREN_out)
RegWr_ex  in  1  EX instruction writes register (ID/EX RegWr_out)
wsel_ex  in  5  EX destination register (ID/EX wsel_out)
jumpFlush_ex  in  1  jump resolved in EX (ID/EX jumpFlush_out)
branch_taken_ex  in  1  branch resolved taken in EX
rs_id  in  5  rs of instruction in ID
rt_id  in  5  rt of instruction in ID
uses_rt_id  in  1  ID instruction reads rt
pc_en  out  1  PC write enable
ifid_en, ifid_flush  out  1 each  IF/ID latch controls
idex_en, idex_flush  out  1 each  ID/EX latch controls
exmem_en, exmem_flush  out  1 each  EX/MEM latch controls
memwb_en, memwb_flush  out  1 each  MEM/WB latch controls
halted  out  1  processor halted (sticky)
stall_cnt  out  CNT_W  cycles with pc_en=0 while in RUN
flush_cnt  out  CNT_W  redirect flush events

Behaviour:
- Latch contract: a latch loads on CLK when en=1; it loads zeros (bubble) when en=1 and flush=1; it holds when en=0.
- Derived terms:
  - mem_stall = (dREN_mem | dWEN_mem) & ~dhit
  - redirect = branch_taken_ex | jumpFlush_ex
  - load_use = dREN_ex & RegWr_ex & (wsel_ex != 0) & ((wsel_ex == rs_id) | (uses_rt_id & wsel_ex == rt_id))
- FSM has two states, RUN and HALTED. Reset state is RUN.
- Outputs in RUN are combinational. First matching row wins:
  1. mem_stall, or (~ihit & redirect): freeze.
     - pc, ifid, idex and exmem en = 0.
     - memwb_en=1, memwb_flush=1.
     - A redirect held this way is re-evaluated next cycle.
  2. halt_mem: pc, ifid and idex en = 0; exmem_en=1 with exmem_flush=1; memwb_en=1. Next state HALTED.
  3. ~ihit: pc_en=0, ifid_en=0; idex_en=1 with idex_flush=1; exmem_en=1; memwb_en=1.
  4. redirect: all en=1; ifid_flush=1, idex_flush=1; the other flushes = 0.
  5. load_use: pc_en=0, ifid_en=0; idex_en=1 with idex_flush=1; exmem_en=1; memwb_en=1.
  6. Otherwise all en=1 and all flush=0.
- HALTED: all en=0, all flush=0, halted=1. Only RST leaves HALTED.
- Reset values: state=RUN, halted=0, stall_cnt=0, flush_cnt=0. Enables follow the RUN equations immediately after reset.
- RST asserted mid-stall or mid-halt returns to RUN asynchronously and clears the counters.
- stall_cnt: +1 on each RUN cycle with pc_en=0, including the halt cycle. Saturates at all-ones and never wraps.
- flush_cnt: +1 on each cycle where row 4 is selected. Saturates at all-ones.
- Both counters freeze in HALTED.
- wsel_ex=0 never causes a load-use stall.
- A load-use hazard coincident with a redirect yields only the redirect, because the ID instruction is flushed.
- Single-cycle decision latency: no registered delay on the enable/flush outputs.

Test Plan:
- RST=1, then release with ihit=1 and no hazards → all en=1, all flush=0, halted=0, counters 0.
- dREN_ex=1, RegWr_ex=1, wsel_ex=8, rs_id=8, ihit=1 → pc_en=0, ifid_en=0, idex_flush=1; stall_cnt goes 0→1. With wsel_ex=0 instead → no stall.
- branch_taken_ex=1, ihit=0 for 2 cycles, then ihit=1:
  - first 2 cycles: freeze, memwb_flush=1;
  - third cycle: ifid_flush=idex_flush=1, pc_en=1;
  - flush_cnt=1, stall_cnt=2.
- dWEN_mem=1, dhit=0 for 3 cycles while load_use is also true → freeze for 3 cycles, then load_use bubble; stall_cnt=4.
- halt_mem=1 → that cycle exmem_flush=1, memwb_en=1; next cycle halted=1 with all en=0 and counters frozen. Pulse RST → halted=0, state RUN.
- Force stall_cnt to 2^CNT_W−1 (CNT_W=4: 15) and stall again → stays 15.
